// File: rtl/lbus_host_ctrl_if.sv
// ---------------------------------------------------------------------------
// lbus_host_ctrl_if
//  Groups the command/response handshake and the SASEBO-GIII local bus pins
//  of lbus_host_ctrl.
//  slave  : view of the controller (takes commands, drives the local bus)
//  master : view of the command source / bus responder (testbench, system)
//  Signals: cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata, rsp_valid/rsp_rdata,
//           lbus_di_a/lbus_wrn/lbus_rdn (to responder), lbus_do (from responder).
//  Macro LBUS_POLL_EN adds cmd_poll and rsp_timeout.
// ---------------------------------------------------------------------------
interface lbus_host_ctrl_if;
   localparam int unsigned DW = 16;

   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_wr;
   logic [DW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [DW-1:0] lbus_di_a;
   logic          lbus_wrn;
   logic          lbus_rdn;
   logic [DW-1:0] lbus_do;

`ifdef LBUS_POLL_EN
   logic          cmd_poll;
   logic          rsp_timeout;

   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_poll, lbus_do,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, lbus_di_a, lbus_wrn, lbus_rdn
   );
   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_poll, lbus_do,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout, lbus_di_a, lbus_wrn, lbus_rdn
   );
`else
   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, lbus_do,
      output cmd_ready, rsp_valid, rsp_rdata, lbus_di_a, lbus_wrn, lbus_rdn
   );
   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, lbus_do,
      input  cmd_ready, rsp_valid, rsp_rdata, lbus_di_a, lbus_wrn, lbus_rdn
   );
`endif
endinterface

// File: rtl/lbus_host_ctrl.sv
// ---------------------------------------------------------------------------
// lbus_host_ctrl
//  Initiator of the SASEBO-GIII 16-bit multiplexed local bus. Turns single
//  write/read commands into ADDR -> STRB -> HOLD -> DONE bus cycles and
//  returns read data with a one-cycle rsp_valid pulse.
//  Ports: clk, rstn (async active-low), lb (lbus_host_ctrl_if.slave).
//  Parameters: T_SETUP, T_STROBE, T_HOLD (cycles, each >= 1),
//              POLL_MAX (reads per poll, LBUS_POLL_EN only).
//  Macro LBUS_POLL_EN: enables poll commands (cmd_poll / rsp_timeout).
//  All outputs come straight from flops; strobes are glitch-free.
// ---------------------------------------------------------------------------
module lbus_host_ctrl #(
   parameter int unsigned T_SETUP  = 2,
   parameter int unsigned T_STROBE = 3,
   parameter int unsigned T_HOLD   = 1
`ifdef LBUS_POLL_EN
   ,
   parameter int unsigned POLL_MAX = 1024
`endif
) (
   input logic             clk,
   input logic             rstn,
   lbus_host_ctrl_if.slave lb
);
   localparam int unsigned DW    = 16;
   localparam int unsigned T_SH  = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
   localparam int unsigned T_MAX = (T_STROBE > T_SH) ? T_STROBE : T_SH;
   localparam int unsigned CW    = $clog2(T_MAX) + 1;
`ifdef LBUS_POLL_EN
   localparam int unsigned PW    = $clog2(POLL_MAX + 1);
`endif

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STRB, S_HOLD, S_DONE} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          wr_now_c, wr_nxt_c;

   logic [DW-1:0] di_a_q, di_a_d;
   logic          wrn_q, wrn_d;
   logic          rdn_q, rdn_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          cmd_ready_q, cmd_ready_d;

`ifdef LBUS_POLL_EN
   logic          poll_q, poll_d;
   logic [PW-1:0] poll_cnt_q, poll_cnt_d;
   logic          timeout_q, timeout_d;
   logic          poll_to_c;

   // a poll is a sequence of reads, whatever cmd_wr says
   assign wr_now_c = wr_q & ~poll_q;
   assign wr_nxt_c = wr_d & ~poll_d;
`else
   assign wr_now_c = wr_q;
   assign wr_nxt_c = wr_d;
`endif

   // State register: FSM, phase counter and latched command
   always_ff @(posedge clk or negedge rstn) begin : state_reg
      if (!rstn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
`ifdef LBUS_POLL_EN
         poll_q     <= 1'b0;
         poll_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_q       <= wr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
`ifdef LBUS_POLL_EN
         poll_q     <= poll_d;
         poll_cnt_q <= poll_cnt_d;
`endif
      end
   end

   // Next-state logic; the counter restarts at 0 on every phase change
   always_comb begin : next_state
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef LBUS_POLL_EN
      poll_d     = poll_q;
      poll_cnt_d = poll_cnt_q;
      poll_to_c  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (lb.cmd_valid) begin
               state_d = S_ADDR;
               cnt_d   = '0;
               wr_d    = lb.cmd_wr;
               addr_d  = lb.cmd_addr;
               wdata_d = lb.cmd_wdata;
`ifdef LBUS_POLL_EN
               poll_d     = lb.cmd_poll;
               poll_cnt_d = '0;
`endif
            end
         end
         S_ADDR: begin
            if (cnt_q == CW'(T_SETUP - 1)) begin
               state_d = S_STRB;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STRB: begin
            if (cnt_q == CW'(T_STROBE - 1)) begin
               state_d = S_HOLD;
               cnt_d   = '0;
               if (!wr_now_c) begin
                  rdata_d = lb.lbus_do;
               end
`ifdef LBUS_POLL_EN
               if (poll_q) begin
                  poll_cnt_d = poll_cnt_q + PW'(1);
               end
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_HOLD: begin
            if (cnt_q == CW'(T_HOLD - 1)) begin
               state_d = S_DONE;
               cnt_d   = '0;
`ifdef LBUS_POLL_EN
               // masked bits still set: read again unless the budget is spent
               if (poll_q && ((rdata_q & wdata_q) != '0)) begin
                  if (poll_cnt_q >= PW'(POLL_MAX)) begin
                     poll_to_c = 1'b1;
                  end else begin
                     state_d = S_ADDR;
                  end
               end
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic, decoded from the next state so the flops line up with it
   always_comb begin : out_logic
      di_a_d      = di_a_q;
      wrn_d       = 1'b1;
      rdn_d       = 1'b1;
      rsp_valid_d = 1'b0;
      cmd_ready_d = 1'b0;
`ifdef LBUS_POLL_EN
      timeout_d   = 1'b0;
`endif
      case (state_d)
         S_IDLE: cmd_ready_d = 1'b1;
         S_ADDR: di_a_d = addr_d;
         S_STRB: begin
            di_a_d = wr_nxt_c ? wdata_d : addr_d;
            wrn_d  = ~wr_nxt_c;
            rdn_d  = wr_nxt_c;
         end
         S_HOLD: di_a_d = wr_nxt_c ? wdata_d : addr_d;
         S_DONE: begin
            rsp_valid_d = 1'b1;
`ifdef LBUS_POLL_EN
            timeout_d   = poll_to_c;
`endif
         end
         default: ;
      endcase
   end

   // Output registers; async reset parks both strobes high immediately
   always_ff @(posedge clk or negedge rstn) begin : out_reg
      if (!rstn) begin
         di_a_q      <= '0;
         wrn_q       <= 1'b1;
         rdn_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b1;
`ifdef LBUS_POLL_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         di_a_q      <= di_a_d;
         wrn_q       <= wrn_d;
         rdn_q       <= rdn_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
`ifdef LBUS_POLL_EN
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign lb.lbus_di_a = di_a_q;
   assign lb.lbus_wrn  = wrn_q;
   assign lb.lbus_rdn  = rdn_q;
   assign lb.rsp_valid = rsp_valid_q;
   assign lb.rsp_rdata = rdata_q;
   assign lb.cmd_ready = cmd_ready_q;
`ifdef LBUS_POLL_EN
   assign lb.rsp_timeout = timeout_q;
`endif

endmodule
